// File: rtl/riscv_core_fetch_aligner_if.sv
// Bundle of fetch-side, redirect and decoder-side signals around the fetch aligner.
// The slave modport is the aligner's view; master is the surrounding pipeline's view.
interface riscv_core_fetch_aligner_if #(
    parameter int unsigned XLEN = 64
);
    logic [31:0]     i_aligner_fetch_data;
    logic            i_aligner_fetch_valid;
    logic            o_aligner_fetch_ready;
    logic            i_aligner_redirect_valid;
    logic [XLEN-1:0] i_aligner_redirect_pc;
    logic [31:0]     o_aligner_instr;
    logic [XLEN-1:0] o_aligner_pc;
    logic            o_aligner_valid;
    logic            i_aligner_ready;

    modport slave (
        input  i_aligner_fetch_data,
        input  i_aligner_fetch_valid,
        output o_aligner_fetch_ready,
        input  i_aligner_redirect_valid,
        input  i_aligner_redirect_pc,
        output o_aligner_instr,
        output o_aligner_pc,
        output o_aligner_valid,
        input  i_aligner_ready
    );

    modport master (
        output i_aligner_fetch_data,
        output i_aligner_fetch_valid,
        input  o_aligner_fetch_ready,
        output i_aligner_redirect_valid,
        output i_aligner_redirect_pc,
        input  o_aligner_instr,
        input  o_aligner_pc,
        input  o_aligner_valid,
        output i_aligner_ready
    );
endinterface

// File: rtl/riscv_core_fetch_aligner.sv
// Turns word-aligned fetch words into one instruction per beat, handling RVC halfwords
// and 32-bit instructions that straddle two fetch words; flushes on redirect.
module riscv_core_fetch_aligner #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_1000
) (
    input logic                       i_clk,
    input logic                       i_rst,
    riscv_core_fetch_aligner_if.slave aligner_if
);

    typedef enum logic {
        ST_EMPTY,
        ST_HALF
    } state_e;

    state_e          r_state,   w_state_nxt;
    logic            r_skip,    w_skip_nxt;
    logic [15:0]     r_buf,     w_buf_nxt;
    logic [XLEN-1:0] r_next_pc, w_next_pc_nxt;
    logic [31:0]     r_instr,   w_instr_nxt;
    logic [XLEN-1:0] r_pc,      w_pc_nxt;
    logic            r_valid,   w_valid_nxt;

    logic            w_slot_free;
    logic            w_fetch_ready;
    logic            w_emit;
    logic [31:0]     w_word;
    logic            w_unused_redirect_bit0;

    function automatic logic is_rvc(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

    assign w_word                 = aligner_if.i_aligner_fetch_data;
    assign w_slot_free            = !r_valid || aligner_if.i_aligner_ready;
    assign w_unused_redirect_bit0 = aligner_if.i_aligner_redirect_pc[0];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_state_nxt   = r_state;
        w_skip_nxt    = r_skip;
        w_buf_nxt     = r_buf;
        w_next_pc_nxt = r_next_pc;
        w_instr_nxt   = r_instr;
        w_pc_nxt      = r_pc;
        w_valid_nxt   = r_valid && !aligner_if.i_aligner_ready;
        w_fetch_ready = 1'b0;
        w_emit        = 1'b0;

        if (aligner_if.i_aligner_redirect_valid) begin
            // Redirect wins over everything, including a stalled beat that was never delivered.
            w_state_nxt   = ST_EMPTY;
            w_skip_nxt    = aligner_if.i_aligner_redirect_pc[1];
            w_next_pc_nxt = {aligner_if.i_aligner_redirect_pc[XLEN-1:1], 1'b0};
            w_valid_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (r_skip) begin
                        w_fetch_ready = 1'b1;
                        if (aligner_if.i_aligner_fetch_valid) begin
                            w_buf_nxt   = w_word[31:16];
                            w_state_nxt = ST_HALF;
                            w_skip_nxt  = 1'b0;
                        end
                    end else begin
                        w_fetch_ready = w_slot_free;
                        if (aligner_if.i_aligner_fetch_valid && w_slot_free) begin
                            w_emit   = 1'b1;
                            w_pc_nxt = r_next_pc;
                            if (is_rvc(w_word[15:0])) begin
                                w_instr_nxt   = {16'h0000, w_word[15:0]};
                                w_buf_nxt     = w_word[31:16];
                                w_state_nxt   = ST_HALF;
                                w_next_pc_nxt = r_next_pc + XLEN'(2);
                            end else begin
                                w_instr_nxt   = w_word;
                                w_next_pc_nxt = r_next_pc + XLEN'(4);
                            end
                        end
                    end
                end
                ST_HALF: begin
                    if (is_rvc(r_buf)) begin
                        // Drain the buffered RVC before taking another word.
                        if (w_slot_free) begin
                            w_emit        = 1'b1;
                            w_pc_nxt      = r_next_pc;
                            w_instr_nxt   = {16'h0000, r_buf};
                            w_state_nxt   = ST_EMPTY;
                            w_next_pc_nxt = r_next_pc + XLEN'(2);
                        end
                    end else begin
                        w_fetch_ready = w_slot_free;
                        if (aligner_if.i_aligner_fetch_valid && w_slot_free) begin
                            w_emit        = 1'b1;
                            w_pc_nxt      = r_next_pc;
                            w_instr_nxt   = {w_word[15:0], r_buf};
                            w_buf_nxt     = w_word[31:16];
                            w_next_pc_nxt = r_next_pc + XLEN'(4);
                        end
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end

        if (w_emit) begin
            w_valid_nxt = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_EMPTY;
            r_skip    <= RESET_PC[1];
            r_buf     <= 16'h0000;
            r_next_pc <= {RESET_PC[XLEN-1:1], 1'b0};
            r_instr   <= 32'h0000_0000;
            r_pc      <= RESET_PC;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_skip    <= w_skip_nxt;
            r_buf     <= w_buf_nxt;
            r_next_pc <= w_next_pc_nxt;
            r_instr   <= w_instr_nxt;
            r_pc      <= w_pc_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    assign aligner_if.o_aligner_fetch_ready = w_fetch_ready;
    assign aligner_if.o_aligner_instr       = r_instr;
    assign aligner_if.o_aligner_pc          = r_pc;
    assign aligner_if.o_aligner_valid       = r_valid;

endmodule

// File: tb/tb_riscv_core_fetch_aligner.sv
// Directed self-checking bench for riscv_core_fetch_aligner with hand-computed beats.
module tb_riscv_core_fetch_aligner;

    localparam int unsigned XLEN = 64;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    riscv_core_fetch_aligner_if #(.XLEN(XLEN)) bus ();

    riscv_core_fetch_aligner #(
        .XLEN    (XLEN),
        .RESET_PC(64'h0000_1000)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .aligner_if(bus.slave)
    );

    // Packed {valid, instr, pc} view of the output beat.
    wire [96:0] w_beat = {bus.o_aligner_valid, bus.o_aligner_instr, bus.o_aligner_pc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic vld, input logic [31:0] data);
        bus.i_aligner_fetch_valid = vld;
        bus.i_aligner_fetch_data  = data;
    endtask

    task automatic apply_redirect(input logic [XLEN-1:0] pc);
        bus.i_aligner_redirect_valid = 1'b1;
        bus.i_aligner_redirect_pc    = pc;
        tick();
        bus.i_aligner_redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_vec++;
        if (w_beat !== {1'b0, 32'h0, 64'h1000}) begin
            n_err++;
            $display("FAIL reset_beat: got %h required %h", w_beat, {1'b0, 32'h0, 64'h1000});
        end
        n_vec++;
        if (bus.o_aligner_fetch_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_fetch_ready: got %b required 1", bus.o_aligner_fetch_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Test 1: single 32-bit instruction straight after reset.
    task automatic test_single_32();
        present(1'b1, 32'h00A00093);
        tick();
        present(1'b0, 32'h0);
        n_vec++;
        if (w_beat !== {1'b1, 32'h00A00093, 64'h1000}) begin
            n_err++;
            $display("FAIL t1_beat: got %h required %h", w_beat, {1'b1, 32'h00A00093, 64'h1000});
        end
        tick();
        n_vec++;
        if (bus.o_aligner_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t1_drain: valid got %b required 0", bus.o_aligner_valid);
        end
    endtask

    // Test 2: one word holding two RVC instructions takes two beats.
    task automatic test_two_rvc();
        apply_redirect(64'h1000);
        present(1'b1, 32'h45054501);
        tick();
        n_vec++;
        if (w_beat !== {1'b1, 32'h00004501, 64'h1000}) begin
            n_err++;
            $display("FAIL t2_beat0: got %h required %h", w_beat, {1'b1, 32'h00004501, 64'h1000});
        end
        n_vec++;
        if (bus.o_aligner_fetch_ready !== 1'b0) begin
            n_err++;
            $display("FAIL t2_fetch_ready: got %b required 0", bus.o_aligner_fetch_ready);
        end
        present(1'b0, 32'h0);
        tick();
        n_vec++;
        if (w_beat !== {1'b1, 32'h00004505, 64'h1002}) begin
            n_err++;
            $display("FAIL t2_beat1: got %h required %h", w_beat, {1'b1, 32'h00004505, 64'h1002});
        end
        tick();
        n_vec++;
        if (bus.o_aligner_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t2_drain: valid got %b required 0", bus.o_aligner_valid);
        end
    endtask

    // Test 3: RVC, then a 32-bit instruction straddling two words, then RVC.
    task automatic test_straddle();
        apply_redirect(64'h1000);
        present(1'b1, 32'h00934501);
        tick();
        n_vec++;
        if (w_beat !== {1'b1, 32'h00004501, 64'h1000}) begin
            n_err++;
            $display("FAIL t3_beat0: got %h required %h", w_beat, {1'b1, 32'h00004501, 64'h1000});
        end
        present(1'b1, 32'h450100A0);
        tick();
        present(1'b0, 32'h0);
        n_vec++;
        if (w_beat !== {1'b1, 32'h00A00093, 64'h1002}) begin
            n_err++;
            $display("FAIL t3_beat1: got %h required %h", w_beat, {1'b1, 32'h00A00093, 64'h1002});
        end
        tick();
        n_vec++;
        if (w_beat !== {1'b1, 32'h00004501, 64'h1006}) begin
            n_err++;
            $display("FAIL t3_beat2: got %h required %h", w_beat, {1'b1, 32'h00004501, 64'h1006});
        end
        tick();
        n_vec++;
        if (bus.o_aligner_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t3_drain: valid got %b required 0", bus.o_aligner_valid);
        end
    endtask

    // Test 4: redirect to an odd halfword drops the low half of the first word.
    task automatic test_redirect_skip();
        present(1'b1, 32'hDEADBEEF);
        bus.i_aligner_redirect_valid = 1'b1;
        bus.i_aligner_redirect_pc    = 64'h2002;
        #1;
        n_vec++;
        if (bus.o_aligner_fetch_ready !== 1'b0) begin
            n_err++;
            $display("FAIL t4_redirect_blocks: fetch_ready got %b required 0", bus.o_aligner_fetch_ready);
        end
        tick();
        bus.i_aligner_redirect_valid = 1'b0;
        present(1'b1, 32'h4505ABCD);
        n_vec++;
        if (bus.o_aligner_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t4_flush: valid got %b required 0", bus.o_aligner_valid);
        end
        tick();
        present(1'b0, 32'h0);
        n_vec++;
        if (bus.o_aligner_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t4_low_dropped: valid got %b required 0", bus.o_aligner_valid);
        end
        tick();
        n_vec++;
        if (w_beat !== {1'b1, 32'h00004505, 64'h2002}) begin
            n_err++;
            $display("FAIL t4_beat: got %h required %h", w_beat, {1'b1, 32'h00004505, 64'h2002});
        end
        tick();
        n_vec++;
        if (bus.o_aligner_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t4_drain: valid got %b required 0", bus.o_aligner_valid);
        end
    endtask

    // Test 5: downstream stall for three cycles in the middle of test 3.
    task automatic test_stall();
        apply_redirect(64'h1000);
        present(1'b1, 32'h00934501);
        tick();
        present(1'b1, 32'h450100A0);
        bus.i_aligner_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (w_beat !== {1'b1, 32'h00004501, 64'h1000}) begin
                n_err++;
                $display("FAIL t5_hold%0d: got %h required %h", i, w_beat, {1'b1, 32'h00004501, 64'h1000});
            end
            n_vec++;
            if (bus.o_aligner_fetch_ready !== 1'b0) begin
                n_err++;
                $display("FAIL t5_no_accept%0d: fetch_ready got %b required 0", i, bus.o_aligner_fetch_ready);
            end
        end
        bus.i_aligner_ready = 1'b1;
        #1;
        n_vec++;
        if (bus.o_aligner_fetch_ready !== 1'b1) begin
            n_err++;
            $display("FAIL t5_release: fetch_ready got %b required 1", bus.o_aligner_fetch_ready);
        end
        tick();
        present(1'b0, 32'h0);
        n_vec++;
        if (w_beat !== {1'b1, 32'h00A00093, 64'h1002}) begin
            n_err++;
            $display("FAIL t5_beat1: got %h required %h", w_beat, {1'b1, 32'h00A00093, 64'h1002});
        end
        tick();
        n_vec++;
        if (w_beat !== {1'b1, 32'h00004501, 64'h1006}) begin
            n_err++;
            $display("FAIL t5_beat2: got %h required %h", w_beat, {1'b1, 32'h00004501, 64'h1006});
        end
        tick();
    endtask

    // Test 6: redirect while a 32-bit low half is buffered and the beat is stalled.
    task automatic test_redirect_stall();
        apply_redirect(64'h1000);
        present(1'b1, 32'h00934501);
        tick();
        present(1'b0, 32'h0);
        bus.i_aligner_ready = 1'b0;
        tick();
        n_vec++;
        if (w_beat !== {1'b1, 32'h00004501, 64'h1000}) begin
            n_err++;
            $display("FAIL t6_stalled: got %h required %h", w_beat, {1'b1, 32'h00004501, 64'h1000});
        end
        apply_redirect(64'h3000);
        n_vec++;
        if (bus.o_aligner_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t6_dropped: valid got %b required 0", bus.o_aligner_valid);
        end
        bus.i_aligner_ready = 1'b1;
        present(1'b1, 32'h00000013);
        tick();
        present(1'b0, 32'h0);
        n_vec++;
        if (w_beat !== {1'b1, 32'h00000013, 64'h3000}) begin
            n_err++;
            $display("FAIL t6_beat: got %h required %h", w_beat, {1'b1, 32'h00000013, 64'h3000});
        end
        tick();
        n_vec++;
        if (bus.o_aligner_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t6_no_stale: valid got %b required 0", bus.o_aligner_valid);
        end
    endtask

    // PC wraps from the top halfword of the address space to zero.
    task automatic test_pc_wrap();
        apply_redirect(64'hFFFF_FFFF_FFFF_FFFE);
        present(1'b1, 32'h00010001);
        tick();
        present(1'b0, 32'h0);
        tick();
        n_vec++;
        if (w_beat !== {1'b1, 32'h00000001, 64'hFFFF_FFFF_FFFF_FFFE}) begin
            n_err++;
            $display("FAIL wrap_top: got %h required %h", w_beat, {1'b1, 32'h00000001, 64'hFFFF_FFFF_FFFF_FFFE});
        end
        present(1'b1, 32'h00A00093);
        tick();
        present(1'b0, 32'h0);
        n_vec++;
        if (w_beat !== {1'b1, 32'h00A00093, 64'h0}) begin
            n_err++;
            $display("FAIL wrap_zero: got %h required %h", w_beat, {1'b1, 32'h00A00093, 64'h0});
        end
        tick();
    endtask

    // Asynchronous reset mid-operation discards the buffered halfword.
    task automatic test_mid_reset();
        apply_redirect(64'h1000);
        present(1'b1, 32'h00934501);
        tick();
        present(1'b0, 32'h0);
        rst = 1'b1;
        #1;
        n_vec++;
        if (w_beat !== {1'b0, 32'h0, 64'h1000}) begin
            n_err++;
            $display("FAIL midrst_beat: got %h required %h", w_beat, {1'b0, 32'h0, 64'h1000});
        end
        tick();
        rst = 1'b0;
        present(1'b1, 32'h00A00093);
        tick();
        present(1'b0, 32'h0);
        n_vec++;
        if (w_beat !== {1'b1, 32'h00A00093, 64'h1000}) begin
            n_err++;
            $display("FAIL midrst_restart: got %h required %h", w_beat, {1'b1, 32'h00A00093, 64'h1000});
        end
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.i_aligner_fetch_data     = 32'h0;
        bus.i_aligner_fetch_valid    = 1'b0;
        bus.i_aligner_redirect_valid = 1'b0;
        bus.i_aligner_redirect_pc    = '0;
        bus.i_aligner_ready          = 1'b1;

        test_reset();
        test_single_32();
        test_two_rvc();
        test_straddle();
        test_redirect_skip();
        test_stall();
        test_redirect_stall();
        test_pc_wrap();
        test_mid_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
